// File: rtl/picorv_bus_fabric.sv
// -----------------------------------------------------------------------------
// picorv_bus_fabric
//
// N-slave interconnect between the PicoRV32 native memory port and on-chip
// peripherals. A request is decoded by mask/base compare, the winning slave is
// selected with a registered one-hot s_sel, and the single-beat response
// (m_ready/m_rdata) is returned registered. A slave that never answers is cut
// off after TIMEOUT cycles, and an unmapped address is answered immediately
// with ERR_RDATA, so the CPU never hangs. Bus errors are captured in a sticky
// flag (err_irq) with the address of the first unacknowledged error.
//
// Optional build macro: BUS_ERR_COUNT_EN
//   defined   -> adds err_count[15:0], a saturating count of flagged errors
//   undefined -> no err_count port, behaviour otherwise identical
//
// Ports:
//   clk_i     in   1            system clock
//   rst_i     in   1            asynchronous active-high reset
//   m_valid   in   1            CPU mem_valid
//   m_addr    in   32           CPU mem_addr (also routed straight to slaves)
//   m_wstrb   in   4            CPU mem_wstrb, 0 = read (routed straight to slaves)
//   m_wdata   in   32           CPU mem_wdata (routed straight to slaves)
//   m_ready   out  1            CPU mem_ready, registered, one-cycle pulse
//   m_rdata   out  32           CPU mem_rdata, registered
//   s_sel     out  N_SLAVES     one-hot slave select, registered
//   s_ready   in   N_SLAVES     per-slave ready
//   s_rdata   in   N_SLAVES*32  per-slave read data, slave i at [32*i+31:32*i]
//   err_irq   out  1            sticky bus-error level for the CPU irq vector
//   err_addr  out  32           address of the first unacknowledged error
//   err_clr   in   1            single-cycle pulse clearing err_irq
//   err_count out  16           (BUS_ERR_COUNT_EN only) saturating error count
// -----------------------------------------------------------------------------
module picorv_bus_fabric #(
    parameter int                     N_SLAVES  = 4,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE  = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLV_MASK  = {N_SLAVES{32'hFFFF_FFFF}},
    parameter int                     TIMEOUT   = 255,
    parameter logic [31:0]            ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_valid,
    input  logic [31:0]            m_addr,
    input  logic [3:0]             m_wstrb,
    input  logic [31:0]            m_wdata,
    output logic                   m_ready,
    output logic [31:0]            m_rdata,
    output logic [N_SLAVES-1:0]    s_sel,
    input  logic [N_SLAVES-1:0]    s_ready,
    input  logic [N_SLAVES*32-1:0] s_rdata,
    output logic                   err_irq,
    output logic [31:0]            err_addr,
    input  logic                   err_clr
`ifdef BUS_ERR_COUNT_EN
    ,
    output logic [15:0]            err_count
`endif
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [N_SLAVES-1:0] sel_n;
    logic                ready_n;
    logic [31:0]         rdata_n;
    logic                err_evt;

    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    // Write data and strobes go straight to the slaves; the fabric itself
    // never inspects them.
    logic unused_inputs;
    assign unused_inputs = ^{m_wstrb, m_wdata};

    // Address decode. Scanning from the top index down lets the lowest
    // matching index overwrite the others, so it wins on overlapping windows.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Only the latched slave's ready/data are ever looked at.
    assign sel_ready = s_ready[idx];
    assign sel_rdata = s_rdata[32*idx +: 32];

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        sel_n   = s_sel;
        ready_n = 1'b0;
        rdata_n = m_rdata;
        err_evt = 1'b0;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    if (hit_any) begin
                        idx_n   = hit_idx;
                        sel_n   = N_SLAVES'(1) << hit_idx;
                        cnt_n   = '0;
                        state_n = BUSY;
                    end else begin
                        rdata_n = ERR_RDATA;
                        ready_n = 1'b1;
                        err_evt = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            BUSY: begin
                if (!m_valid) begin
                    // CPU withdrew the request: drop the slave quietly.
                    sel_n   = '0;
                    state_n = IDLE;
                end else if (sel_ready) begin
                    rdata_n = sel_rdata;
                    ready_n = 1'b1;
                    sel_n   = '0;
                    state_n = DONE;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    rdata_n = ERR_RDATA;
                    ready_n = 1'b1;
                    sel_n   = '0;
                    err_evt = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                sel_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx     <= '0;
            cnt     <= '0;
            s_sel   <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
        end else begin
            idx     <= idx_n;
            cnt     <= cnt_n;
            s_sel   <= sel_n;
            m_ready <= ready_n;
            m_rdata <= rdata_n;
        end
    end

    // Sticky error capture. A new error beats a simultaneous clear and then
    // counts as the first error of the new window, so its address is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_irq  <= 1'b0;
            err_addr <= '0;
        end else if (err_evt) begin
            if (!err_irq || err_clr) begin
                err_irq  <= 1'b1;
                err_addr <= m_addr;
            end
        end else if (err_clr) begin
            err_irq <= 1'b0;
        end
    end

`ifdef BUS_ERR_COUNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_count <= '0;
        end else if (err_evt) begin
            if (err_clr) begin
                err_count <= 16'd1;
            end else if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end else if (err_clr) begin
            err_count <= '0;
        end
    end
`endif

endmodule
